// File: rtl/ram_dump_uart.sv
// ram_dump_uart: on a rising edge of i_start, reads i_word_count words from
// RAM starting at i_base_addr and sends each word, byte by byte, as 8N1/8N2
// UART frames on o_tx.
// Optional build macro RAM_DUMP_UART_PARITY_EN adds an even-parity bit after
// data bit 7 of every frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a start edge; line idle high
// S_FETCH   | one-cycle RAM read strobe for the current address
// S_WAIT_RD | waiting out the RAM read latency (skipped when latency is 0)
// S_START   | start bit (0)
// S_DATA    | eight data bits, LSB first
// S_PARITY  | even-parity bit (only reachable with the parity build)
// S_STOP    | stop bit(s); then next byte, next word, or done
// S_DONE    | one-cycle completion pulse
module ram_dump_uart #(
  parameter int DATA_LENGTH  = 16,
  parameter int ADDR_LENGTH  = 11,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1,
  parameter int RD_LATENCY   = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [ADDR_LENGTH-1:0] i_base_addr,
  input  logic [ADDR_LENGTH:0]   i_word_count,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic                   o_Rd,
  input  logic [DATA_LENGTH-1:0] i_Data,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NBYTES = DATA_LENGTH / 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]           BYTE_LAST = 3'(NBYTES - 1);
  localparam logic [1:0]           LAT_LAST  = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [ADDR_LENGTH:0] WORD_ONE  = (ADDR_LENGTH+1)'(1);
  localparam logic [ADDR_LENGTH-1:0] ADDR_ONE = ADDR_LENGTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic                   start_prev;
  logic                   start_edge;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [ADDR_LENGTH:0]   words_left;
  logic [DATA_LENGTH-1:0] word_q;
  logic [2:0]             byte_left;
  logic [2:0]             bit_idx;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   stop_idx;
  logic [1:0]             lat_cnt;
  logic [7:0]             cur_byte;
  logic                   bit_end;
  logic                   in_frame;
  logic                   capture;

  assign start_edge = i_start & ~start_prev;
  assign bit_end    = (bit_cnt == '0);
  assign in_frame   = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
  assign capture    = ((state == S_FETCH) && (RD_LATENCY == 0)) ||
                      ((state == S_WAIT_RD) && (lat_cnt == '0));
  assign o_Addr     = addr_q;

  // Byte currently on the line: the word register is shifted after each
  // byte so the outgoing byte always sits at the same end.
  always_comb begin
    cur_byte = word_q[7:0];
    if (MSB_FIRST != 0) cur_byte = word_q[DATA_LENGTH-1 -: 8];
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Previous i_start for edge detection. Resets to 1 so that a level still
  // high when reset releases is not mistaken for a fresh request.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) start_prev <= 1'b1;
    else          start_prev <= i_start;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt = state;
    o_tx      = 1'b1;
    o_Rd      = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge) state_nxt = (i_word_count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        o_Rd      = 1'b1;
        o_busy    = 1'b1;
        state_nxt = (RD_LATENCY == 0) ? S_START : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        o_busy = 1'b1;
        if (lat_cnt == '0) state_nxt = S_START;
      end
      S_START: begin
        o_tx   = 1'b0;
        o_busy = 1'b1;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        o_tx   = cur_byte[bit_idx];
        o_busy = 1'b1;
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef RAM_DUMP_UART_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        o_tx   = ^cur_byte;
        o_busy = 1'b1;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        o_busy = 1'b1;
        if (bit_end && (stop_idx == STOP_LAST)) begin
          // Next byte of the same word goes out with no idle gap; a new
          // word needs a fresh RAM read first.
          if (byte_left != '0)              state_nxt = S_START;
          else if (words_left == WORD_ONE)  state_nxt = S_DONE;
          else                              state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, word counter, read-latency timer and word/byte registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      addr_q     <= '0;
      words_left <= '0;
      lat_cnt    <= '0;
      word_q     <= '0;
      byte_left  <= '0;
    end else begin
      if ((state == S_IDLE) && start_edge) begin
        words_left <= i_word_count;
        // A zero-length request never reads, so the bus address is left alone.
        if (i_word_count != '0) addr_q <= i_base_addr;
      end
      if ((state == S_STOP) && (state_nxt == S_FETCH)) begin
        addr_q     <= addr_q + ADDR_ONE;
        words_left <= words_left - WORD_ONE;
      end
      if (state == S_FETCH)   lat_cnt <= LAT_LAST;
      if (state == S_WAIT_RD) lat_cnt <= lat_cnt - 2'd1;
      if (capture) begin
        word_q    <= i_Data;
        byte_left <= BYTE_LAST;
      end else if ((state == S_STOP) && (state_nxt == S_START)) begin
        byte_left <= byte_left - 3'd1;
        if (MSB_FIRST != 0) word_q <= word_q << 8;
        else                word_q <= word_q >> 8;
      end
    end
  end

  // Bit timing: down-counter per bit, data-bit index and stop-bit index.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (!in_frame || bit_end) bit_cnt <= BIT_LAST;
      else                      bit_cnt <= bit_cnt - CNT_ONE;

      if (state != S_DATA)  bit_idx <= '0;
      else if (bit_end)     bit_idx <= bit_idx + 3'd1;

      if (state != S_STOP)  stop_idx <= 1'b0;
      else if (bit_end)     stop_idx <= ~stop_idx;
    end
  end

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: two instances with different parameter sets, each
// with its own RAM model, reference model, expectation queues and monitors.
`timescale 1ns/1ps
module tb_ram_dump_uart;

  localparam int DL = 16;
  localparam int AL = 4;
  localparam int NB = DL / 8;
`ifdef RAM_DUMP_UART_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  typedef struct { logic [7:0] b; int cyc; } frame_t;
  typedef struct { logic [AL-1:0] a; int cyc; } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int CPB = (g == 0) ? 4 : 3;
    localparam int SB  = (g == 0) ? 1 : 2;
    localparam int MSB = (g == 0) ? 1 : 0;
    localparam int LAT = (g == 0) ? 0 : 2;
    localparam int FB  = 9 + PBITS + SB;
    localparam int FC  = FB * CPB;

    logic          rst, start, rd, tx, busy, done, fin;
    logic [AL-1:0] base, addr;
    logic [AL:0]   cnt;
    logic [DL-1:0] data, junk, d1, d2, rdata;
    logic [DL-1:0] ram [16];
    frame_t        fq[$];
    rd_t           rq[$];
    int            dq[$];

    ram_dump_uart #(
      .DATA_LENGTH(DL), .ADDR_LENGTH(AL), .CLKS_PER_BIT(CPB),
      .STOP_BITS(SB), .MSB_FIRST(MSB), .RD_LATENCY(LAT)
    ) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start),
      .i_base_addr(base), .i_word_count(cnt),
      .o_Addr(addr), .o_Rd(rd), .i_Data(data),
      .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    // RAM with LAT cycles of read latency; garbage whenever no read is due.
    always_comb rdata = rd ? ram[addr] : junk;
    always @(posedge clk) begin
      junk <= DL'($urandom);
      d1   <= rdata;
      d2   <= d1;
    end
    assign data = (LAT == 0) ? rdata : ((LAT == 1) ? d1 : d2);

    function automatic logic fbit(input logic [7:0] b, input int j);
      if (j == 0)                    return 1'b0;
      if (j <= 8)                    return b[j-1];
      if ((PBITS == 1) && (j == 9))  return ^b;
      return 1'b1;
    endfunction

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Reference model: from the request cycle, list every read, every frame
    // (byte and start cycle) and the completion cycle.
    task automatic expect_txn(input int b0, input int n, output int dcyc);
      int t, st, idx;
      logic [DL-1:0] w;
      rd_t r;
      frame_t f;
      if (n == 0) begin
        dcyc = cyc + 1;
        dq.push_back(dcyc);
        return;
      end
      t = cyc + 1;
      for (int i = 0; i < n; i++) begin
        r.a = AL'(b0 + i);
        r.cyc = t;
        rq.push_back(r);
        w = ram[r.a];
        st = t + 1 + LAT;
        for (int k = 0; k < NB; k++) begin
          idx = (MSB != 0) ? (NB - 1 - k) : k;
          f.b = 8'(w >> (8 * idx));
          f.cyc = st;
          fq.push_back(f);
          st += FC;
        end
        t = st;
      end
      dcyc = t;
      dq.push_back(t);
    endtask

    task automatic launch(input int b0, input int n, output int dcyc);
      base  = AL'(b0);
      cnt   = (AL+1)'(n);
      start = 1'b1;
      expect_txn(b0, n, dcyc);
      tick();
      start = 1'b0;
      tick();
      base = AL'($urandom);
      cnt  = (AL+1)'($urandom);
    endtask

    task automatic wait_idle(input int budget);
      int i = 0;
      while ((dq.size() != 0) && (i < budget)) begin
        tick();
        i++;
      end
      if (dq.size() != 0) begin
        total++;
        bad++;
        $display("FAIL g%0d timeout: done still pending after %0d cycles, required within budget", g, budget);
        dq.delete(); fq.delete(); rq.delete();
      end
      tick();
    endtask

    task automatic check_reset(input string nm);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd !== 1'b0 || addr !== '0) begin
        bad++;
        $display("FAIL g%0d %s: tx=%b busy=%b done=%b rd=%b addr=%0h, required 1 0 0 0 0",
                 g, nm, tx, busy, done, rd, addr);
      end
    endtask

    // Stimulus.
    initial begin : stim
      int dc, dc2, fs;
      fin = 1'b0; rst = 1'b0; start = 1'b0; base = '0; cnt = '0;
      for (int i = 0; i < 16; i++) ram[i] = DL'($urandom);
      tick(); tick();
      @(negedge clk);
      check_reset("reset_state");
      tick();
      rst = 1'b1;
      tick(); tick();

      if (g == 0) begin
        ram[5] = 16'hA55A;
        launch(5, 1, dc);
      end else begin
        ram[0] = 16'h0001; ram[1] = 16'h0203; ram[2] = 16'h0405;
        launch(0, 3, dc);
      end
      wait_idle(2000);

      launch($urandom_range(0, 15), 0, dc);
      wait_idle(50);

      launch(15, 2, dc);
      wait_idle(2000);

      launch($urandom_range(0, 15), 1, dc);
      while (cyc < dc + 1) tick();
      launch($urandom_range(0, 15), 2, dc2);
      wait_idle(2000);

      launch($urandom_range(0, 15), 2, dc);
      repeat (5) tick();
      start = 1'b1;
      tick(); tick();
      start = 1'b0;
      wait_idle(2000);

      for (int it = 0; it < 6; it++) begin
        for (int i = 0; i < 16; i++) ram[i] = DL'($urandom);
        launch($urandom_range(0, 15), $urandom_range(0, 4), dc);
        wait_idle(3000);
      end

      for (int i = 0; i < 16; i++) ram[i] = DL'($urandom);
      launch($urandom_range(0, 15), 16, dc);
      wait_idle(6000);

      // Reset in the middle of data bit 3 of the first byte.
      launch($urandom_range(0, 15), 2, dc);
      fs = dc - 2 * NB * FC - 1 - LAT;
      fs = fs + 0;
      while (cyc < (fs + 4 * CPB + 1)) tick();
      rst   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check_reset("reset_midframe");
      dq.delete(); fq.delete(); rq.delete();
      tick();
      rst = 1'b1;
      repeat (3 * FC) tick();
      @(negedge clk);
      check_reset("held_start_no_retrigger");
      tick();
      start = 1'b0;
      tick();
      launch($urandom_range(0, 15), 1, dc);
      wait_idle(2000);

      fin = 1'b1;
    end

    // Frame monitor: start-bit timing and per-cycle bit content.
    initial begin : mon_tx
      frame_t e;
      int c0, errs;
      logic ab, have, bz;
      logic [7:0] act;
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && tx === 1'b0) begin
          c0 = cyc; bz = busy; act = '0;
          if (fq.size() == 0) begin
            have = 1'b0;
            e.b = 8'h00; e.cyc = c0;
            total++;
            bad++;
            $display("FAIL g%0d unexpected_frame: start bit at cycle %0d, no frame required", g, c0);
          end else begin
            have = 1'b1;
            e = fq.pop_front();
          end
          errs = 0; ab = 1'b0;
          for (int k = 0; k < FC; k++) begin
            if (k != 0) @(negedge clk);
            if (rst !== 1'b1) begin
              ab = 1'b1;
              break;
            end
            if ((k / CPB >= 1) && (k / CPB <= 8) && (k % CPB == CPB / 2)) act[k / CPB - 1] = tx;
            if (tx !== fbit(e.b, k / CPB)) errs++;
          end
          if (have) begin
            total++;
            if (c0 != e.cyc || bz !== 1'b1) begin
              bad++;
              $display("FAIL g%0d frame_start: cycle %0d busy=%b, required cycle %0d busy=1", g, c0, bz, e.cyc);
            end
            if (!ab) begin
              total++;
              if (errs != 0) begin
                bad++;
                $display("FAIL g%0d frame_bits: got byte %02h (%0d bad cycles), required byte %02h", g, act, errs, e.b);
              end
            end
          end
        end
      end
    end

    // Read-strobe monitor.
    initial begin : mon_rd
      rd_t r;
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && rd === 1'b1) begin
          total++;
          if (rq.size() == 0) begin
            bad++;
            $display("FAIL g%0d unexpected_rd: addr %0h at cycle %0d, no read required", g, addr, cyc);
          end else begin
            r = rq.pop_front();
            if (addr !== r.a || cyc != r.cyc || busy !== 1'b1) begin
              bad++;
              $display("FAIL g%0d rd: addr %0h cycle %0d busy=%b, required addr %0h cycle %0d busy=1",
                       g, addr, cyc, busy, r.a, r.cyc);
            end
          end
        end
      end
    end

    // Completion monitor.
    initial begin : mon_done
      int e;
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && done === 1'b1) begin
          total++;
          if (dq.size() == 0) begin
            bad++;
            $display("FAIL g%0d unexpected_done: at cycle %0d, no completion required", g, cyc);
          end else begin
            e = dq.pop_front();
            if (cyc != e || busy !== 1'b0 || tx !== 1'b1) begin
              bad++;
              $display("FAIL g%0d done: cycle %0d busy=%b tx=%b, required cycle %0d busy=0 tx=1",
                       g, cyc, busy, tx, e);
            end
          end
        end
      end
    end
  end

  initial begin : main
    int i = 0;
    while (!(g_inst[0].fin === 1'b1 && g_inst[1].fin === 1'b1) && i < 80000) begin
      @(posedge clk);
      i++;
    end
    if (!(g_inst[0].fin === 1'b1 && g_inst[1].fin === 1'b1)) begin
      total++;
      bad++;
      $display("FAIL global_timeout: fin=%b%b after %0d cycles, required 11", g_inst[1].fin, g_inst[0].fin, i);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
